// File: rtl/updown_counter.sv
// WIDTH-bit up/down counter with programmable modulus, wrap/saturate mode,
// synchronous load/clear, terminal-count pulse and sticky overflow flag.
module updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_event;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_load_clamped = (load_val > LP_MAX) ? LP_MAX : load_val;

  // Next-state: clr > load > en; a boundary event only happens on an enabled count.
  always_comb begin
    w_count_nxt = r_count;
    w_event     = 1'b0;
    w_ovf_nxt   = ovf_clr ? 1'b0 : r_ovf;
    if (clr) begin
      w_count_nxt = LP_ZERO;
      w_ovf_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (up) begin
        if (r_count == LP_MAX) begin
          w_event     = 1'b1;
          w_count_nxt = SATURATE ? LP_MAX : LP_ZERO;
        end else begin
          w_count_nxt = r_count + LP_ONE;
        end
      end else begin
        if (r_count == LP_ZERO) begin
          w_event     = 1'b1;
          w_count_nxt = SATURATE ? LP_ZERO : LP_MAX;
        end else begin
          w_count_nxt = r_count - LP_ONE;
        end
      end
      if (w_event) begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= LP_ZERO;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_event;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: a decade wrap counter and an 8-bit saturating counter
// share one stimulus stream; a behavioural model predicts both every edge.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       up;
  logic       ovf_clr;

  logic [3:0] a_count;
  logic       a_tc;
  logic       a_ovf;
  logic [7:0] b_count;
  logic       b_tc;
  logic       b_ovf;

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .up(up), .ovf_clr(ovf_clr),
    .count(a_count), .tc(a_tc), .ovf(a_ovf)
  );

  updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .ovf_clr(ovf_clr),
    .count(b_count), .tc(b_tc), .ovf(b_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a_c; int a_t; int a_o;
    int b_c; int b_t; int b_o;
  } exp_t;

  exp_t q_exp[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  int m_cnt[2];
  int m_tc[2];
  int m_ovf[2];
  int m_max[2] = '{9, 255};
  int m_msk[2] = '{15, 255};
  bit m_sat[2] = '{1'b0, 1'b1};

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Predict the next edge from the current inputs, queue it, then compare.
  task automatic step();
    exp_t e;
    exp_t o;
    for (int i = 0; i < 2; i++) begin
      int lv;
      bit ev;
      lv = int'(load_val) & m_msk[i];
      ev = 1'b0;
      if (clr) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (lv > m_max[i]) ? m_max[i] : lv;
        if (ovf_clr) m_ovf[i] = 0;
      end else if (en) begin
        if (up) begin
          if (m_cnt[i] == m_max[i]) begin
            ev = 1'b1;
            m_cnt[i] = m_sat[i] ? m_max[i] : 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            ev = 1'b1;
            m_cnt[i] = m_sat[i] ? 0 : m_max[i];
          end else m_cnt[i] = m_cnt[i] - 1;
        end
        if (ev) m_ovf[i] = 1;
        else if (ovf_clr) m_ovf[i] = 0;
      end else begin
        if (ovf_clr) m_ovf[i] = 0;
      end
      m_tc[i] = int'(ev);
    end
    e.a_c = m_cnt[0]; e.a_t = m_tc[0]; e.a_o = m_ovf[0];
    e.b_c = m_cnt[1]; e.b_t = m_tc[1]; e.b_o = m_ovf[1];
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    o = q_exp.pop_front();
    chk("a_count", int'(a_count), o.a_c);
    chk("a_tc",    int'(a_tc),    o.a_t);
    chk("a_ovf",   int'(a_ovf),   o.a_o);
    chk("b_count", int'(b_count), o.b_c);
    chk("b_tc",    int'(b_tc),    o.b_t);
    chk("b_ovf",   int'(b_ovf),   o.b_o);
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit e,
                       input bit u, input bit oc);
    clr = c; load = l; load_val = 8'(lv); en = e; up = u; ovf_clr = oc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_count"}, int'(a_count), 0);
    chk({tag, "_a_tc"},    int'(a_tc),    0);
    chk({tag, "_a_ovf"},   int'(a_ovf),   0);
    chk({tag, "_b_count"}, int'(b_count), 0);
    chk({tag, "_b_tc"},    int'(b_tc),    0);
    chk({tag, "_b_ovf"},   int'(b_ovf),   0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    model_reset();
    #1;
    chk_zero("rst_t0");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    repeat (5) step();

    // Decade count up through the wrap.
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    repeat (12) step();
    chk("decade_end", int'(a_count), 2);
    chk("decade_ovf", int'(a_ovf), 1);

    // Down through zero, then reverse.
    drive(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    repeat (4) step();
    chk("down_wrap_val", int'(a_count), 8);
    up = 1'b1;
    step();
    chk("dir_change", int'(a_count), 9);

    // Asynchronous reset mid-cycle at count 5.
    drive(1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    step();
    chk("pre_rst", int'(a_count), 5);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("rst_edge");
    rst = 1'b0;

    // Saturate at the top and at the bottom.
    drive(1'b0, 1'b1, 254, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    chk("sat_hi", int'(b_count), 255);
    chk("sat_hi_tc", int'(b_tc), 1);
    drive(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk("sat_lo", int'(b_count), 0);
    chk("sat_lo_tc", int'(b_tc), 1);

    // Priority and clamp.
    drive(1'b0, 1'b1, 13, 1'b0, 1'b1, 1'b0);
    step();
    chk("clamp", int'(a_count), 9);
    drive(1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b0);
    step();
    chk("clr_prio", int'(a_count), 0);
    drive(1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0);
    step();
    chk("load_prio", int'(a_count), 4);

    // Sticky flag: set, clear, set-wins, clear by clr.
    drive(1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    step();
    chk("ovf_set", int'(a_ovf), 1);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    step();
    chk("ovf_clr", int'(a_ovf), 0);
    drive(1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    step();
    chk("ovf_set_wins", int'(a_ovf), 1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("ovf_by_clr", int'(a_ovf), 0);

    // Random traffic with occasional clr/load/ovf_clr.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the fixed 4-bit up-counter: a WIDTH-bit up/down counter with programmable modulus, wrap or saturate mode, synchronous load/clear, terminal-count pulse and sticky overflow flag. It serves as the team's general-purpose event counter, timer and decade/modulo divider, and is single-clock throughout.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥ 2).
- MAX_VAL, 2**WIDTH-1, highest count value. Legal range 1 ≤ MAX_VAL ≤ 2**WIDTH-1; the count range is 0..MAX_VAL.
- SATURATE, 0, boundary behaviour: 0 = wrap (modulo MAX_VAL+1), 1 = hold at the boundary.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- ovf_clr  in  1  synchronous clear of ovf.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky boundary-event flag, registered.

## Operation
- Per-edge priority: rst > clr > load > en. Only one action occurs per cycle.
- rst asserted: count=0, tc=0 and ovf=0 immediately, without waiting for a clock edge. The block holds in this state while rst is high.
- clr: count←0 and tc←0. ovf is cleared unless a boundary event occurs in the same cycle, which it cannot, because clr blocks counting.
- load: count←min(load_val, MAX_VAL). Values above MAX_VAL clamp to MAX_VAL. tc←0.
- en=1 with up=1:
  - count<MAX_VAL → count+1.
  - count==MAX_VAL → boundary event: wrap to 0 (SATURATE=0) or hold at MAX_VAL (SATURATE=1).
- en=1 with up=0:
  - count>0 → count−1.
  - count==0 → boundary event: wrap to MAX_VAL (SATURATE=0) or hold at 0 (SATURATE=1).
- en=0 and no clr/load: count holds and tc←0.
- Boundary event: tc←1 for that cycle's update only and ovf←1.
  - In saturate mode with en held at the boundary, tc remains high every cycle, one event per enabled cycle.
- ovf is sticky:
  - It is cleared by ovf_clr, clr or rst.
  - If a boundary event and ovf_clr occur on the same edge, set wins and ovf=1.
- Direction may change on any cycle and takes effect on that edge. There is no pipeline or history.
- Arithmetic is performed at WIDTH bits. MAX_VAL comparison is exact; no intermediate overflow beyond WIDTH is allowed. With MAX_VAL=2**WIDTH-1 the behaviour is identical to natural binary rollover.

## Timing
- Latency from control inputs (en/up/load/clr/ovf_clr) to count/tc/ovf is one clock edge.
- tc is asserted in the same cycle that count shows the post-event value (0 or MAX_VAL for wrap; unchanged for saturate). It is high for exactly one cycle per event.
- rst deassertion is synchronous to the design by convention. The first count action occurs on the first rising edge with rst low.
- Reset mid-count: outputs go to 0 asynchronously. Any in-flight load, clr or en on that edge is discarded.
- Output reset values: count=0, tc=0, ovf=0.

## Test plan
- **Reset/hold:** rst=1 for 2 cycles, then en=0 for 5 cycles → count=0, tc=0, ovf=0 throughout. Assert rst mid-cycle while count=5 → count=0 before the next edge.
- **Decade wrap (WIDTH=4, MAX_VAL=9, SATURATE=0):** en=1, up=1 for 12 cycles → 1,2,…,9,0,1,2. tc=1 only in the cycle count becomes 0. ovf=1 from then on.
- **Down wrap and direction change:** load 2, then up=0 for 4 cycles → 1,0,9,8 with tc in the 9 cycle. Then up=1 → 9.
- **Saturate (WIDTH=8, SATURATE=1):**
  - Load 254, up=1 for 3 cycles → 255,255,255, with tc=0,1,1.
  - up=0 from count=1 for 3 cycles → 0,0,0, with tc=0,1,1.
- **Priority and clamp (MAX_VAL=9):**
  - load_val=13 → count=9.
  - clr=1, load=1, en=1 on the same edge → count=0.
  - load=1, en=1 with load_val=4 → count=4, not 5.
- **Sticky flag:**
  - ovf_clr alone → ovf=0.
  - ovf_clr coincident with a wrap event → ovf=1.
  - clr → ovf=0.
